// File: rtl/adxl362_spi_responder.sv
// SPI mode-0 device-side model of the ADXL362 register interface.
// Oversamples SCLK/CSN/MOSI on clk; serves ID, X/Y/Z snapshot and POWER_CTL registers.
module adxl362_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  PARTID      = 8'hF2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] accel_x_i,
    input  logic [7:0] accel_y_i,
    input  logic [7:0] accel_z_i,
    input  logic       ACL_SCLK,
    input  logic       ACL_CSN,
    input  logic       ACL_MOSI,
    output logic       ACL_MISO,
    output logic [7:0] power_ctl_o,
    output logic       xfer_done_o,
    output logic       cmd_err_o
);

    localparam logic [7:0] CMD_WRITE   = 8'h0A;
    localparam logic [7:0] CMD_READ    = 8'h0B;
    localparam logic [7:0] ADDR_PCTL   = 8'h2D;
    localparam logic [7:0] ADDR_SRST   = 8'h1F;
    localparam logic [7:0] SRST_KEY    = 8'h52;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, mosi_sync;
    logic                   sclk_q, csn_q, armed;
    logic                   sclk_s, csn_s, mosi_s;
    logic                   sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_in, shift_out, addr;
    logic [7:0]             snap_x, snap_y, snap_z;
    logic                   is_write;
    logic [7:0]             byte_in, rd_addr, rd_data;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign csn_s  = csn_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // CSN edges are only honoured once CSN has been seen high after reset
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign csn_rise  = armed & csn_s & ~csn_q;
    assign csn_fall  = armed & ~csn_s & csn_q;

    assign byte_in = {shift_in[6:0], mosi_s};
    assign rd_addr = (state == ADDR) ? byte_in : addr;

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            8'h00:   rd_data = 8'hAD;
            8'h01:   rd_data = 8'h1D;
            8'h02:   rd_data = PARTID;
            8'h08:   rd_data = snap_x;
            8'h09:   rd_data = snap_y;
            8'h0A:   rd_data = snap_z;
            8'h2D:   rd_data = power_ctl_o;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync   <= '0;
            csn_sync    <= '0;
            mosi_sync   <= '0;
            sclk_q      <= 1'b0;
            csn_q       <= 1'b0;
            armed       <= 1'b0;
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            shift_in    <= 8'h00;
            shift_out   <= 8'h00;
            addr        <= 8'h00;
            snap_x      <= 8'h00;
            snap_y      <= 8'h00;
            snap_z      <= 8'h00;
            is_write    <= 1'b0;
            ACL_MISO    <= 1'b0;
            power_ctl_o <= 8'h00;
            xfer_done_o <= 1'b0;
            cmd_err_o   <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], ACL_SCLK};
            csn_sync    <= {csn_sync[SYNC_STAGES-2:0], ACL_CSN};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], ACL_MOSI};
            sclk_q      <= sclk_s;
            csn_q       <= csn_s;
            armed       <= armed | csn_s;
            xfer_done_o <= 1'b0;
            cmd_err_o   <= 1'b0;

            if (csn_rise) begin
                state       <= IDLE;
                ACL_MISO    <= 1'b0;
                xfer_done_o <= 1'b1;
            end else if (csn_fall) begin
                state    <= CMD;
                bit_cnt  <= 3'd0;
                ACL_MISO <= 1'b0;
                // Axes read as zero unless in measurement mode at frame start
                if (power_ctl_o[1:0] == 2'b10) begin
                    snap_x <= accel_x_i;
                    snap_y <= accel_y_i;
                    snap_z <= accel_z_i;
                end else begin
                    snap_x <= 8'h00;
                    snap_y <= 8'h00;
                    snap_z <= 8'h00;
                end
            end else if (state != IDLE && state != IGNORE) begin
                if (sclk_rise) begin
                    shift_in <= byte_in;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            CMD: begin
                                if (byte_in == CMD_WRITE || byte_in == CMD_READ) begin
                                    state    <= ADDR;
                                    is_write <= (byte_in == CMD_WRITE);
                                end else begin
                                    state     <= IGNORE;
                                    cmd_err_o <= 1'b1;
                                end
                            end
                            ADDR: begin
                                if (is_write) begin
                                    state <= WDATA;
                                    addr  <= byte_in;
                                end else begin
                                    state     <= RDATA;
                                    shift_out <= rd_data;
                                    addr      <= byte_in + 8'd1;
                                end
                            end
                            WDATA: begin
                                if (addr == ADDR_PCTL)
                                    power_ctl_o <= byte_in;
                                else if (addr == ADDR_SRST && byte_in == SRST_KEY)
                                    power_ctl_o <= 8'h00;
                                addr <= addr + 8'd1;
                            end
                            RDATA: begin
                                shift_out <= rd_data;
                                addr      <= addr + 8'd1;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end else if (sclk_fall && state == RDATA) begin
                    ACL_MISO  <= shift_out[7];
                    shift_out <= {shift_out[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Directed bench for adxl362_spi_responder: table of register transactions plus
// hand-written corner sequences (snapshot hold, bad command, abort, mid-frame reset).
module tb_adxl362_spi_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] accel_x_i, accel_y_i, accel_z_i;
    logic       ACL_SCLK, ACL_CSN, ACL_MOSI;
    logic       ACL_MISO;
    logic [7:0] power_ctl_o;
    logic       xfer_done_o, cmd_err_o;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_done  = 0;
    int unsigned n_err   = 0;
    int unsigned n_miso  = 0;

    adxl362_spi_responder #(.SYNC_STAGES(2), .PARTID(8'hF2)) dut (
        .clk        (clk),
        .rst        (rst),
        .accel_x_i  (accel_x_i),
        .accel_y_i  (accel_y_i),
        .accel_z_i  (accel_z_i),
        .ACL_SCLK   (ACL_SCLK),
        .ACL_CSN    (ACL_CSN),
        .ACL_MOSI   (ACL_MOSI),
        .ACL_MISO   (ACL_MISO),
        .power_ctl_o(power_ctl_o),
        .xfer_done_o(xfer_done_o),
        .cmd_err_o  (cmd_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (xfer_done_o) n_done <= n_done + 1;
        if (cmd_err_o)   n_err  <= n_err + 1;
        if (ACL_MISO)    n_miso <= n_miso + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  x;
        int unsigned nrd;
        logic [23:0] exp_rd;
        logic [7:0]  exp_pctl;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One SCLK period is 10 clk; MOSI set while low, MISO sampled just before rising.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            ACL_MOSI = tx[i];
            #50;
            rx[i] = ACL_MISO;
            ACL_SCLK = 1'b1;
            #50;
            ACL_SCLK = 1'b0;
        end
    endtask

    task automatic csn_lo();
        @(negedge clk);
        ACL_CSN = 1'b0;
        #100;
    endtask

    task automatic csn_hi();
        #100;
        ACL_CSN = 1'b1;
        #100;
    endtask

    task automatic read1(input logic [7:0] a, output logic [7:0] d);
        logic [7:0] dummy;
        csn_lo();
        xfer(8'h0B, 8, dummy);
        xfer(a, 8, dummy);
        xfer(8'h00, 8, d);
        csn_hi();
    endtask

    initial begin
        logic [7:0]  rx;
        logic [23:0] rd;
        int unsigned d0, e0, m0;

        vecs[0]  = '{8'h0B, 8'h00, 8'h00, 8'h7F, 3, 24'hAD1DF2, 8'h00};
        vecs[1]  = '{8'h0A, 8'h2D, 8'h02, 8'h7F, 0, 24'h000000, 8'h02};
        vecs[2]  = '{8'h0B, 8'h2D, 8'h00, 8'h7F, 1, 24'h000002, 8'h02};
        vecs[3]  = '{8'h0B, 8'h08, 8'h00, 8'h7F, 3, 24'h7F3344, 8'h02};
        vecs[4]  = '{8'h0A, 8'h1F, 8'h52, 8'h7F, 0, 24'h000000, 8'h00};
        vecs[5]  = '{8'h0B, 8'h08, 8'h00, 8'h7F, 1, 24'h000000, 8'h00};
        vecs[6]  = '{8'h0B, 8'hFF, 8'h00, 8'h7F, 2, 24'h0000AD, 8'h00};
        vecs[7]  = '{8'h0A, 8'h2D, 8'h03, 8'h7F, 0, 24'h000000, 8'h03};
        vecs[8]  = '{8'h0B, 8'h08, 8'h00, 8'h7F, 3, 24'h000000, 8'h03};
        vecs[9]  = '{8'h0A, 8'h1F, 8'h11, 8'h7F, 0, 24'h000000, 8'h03};
        vecs[10] = '{8'h0B, 8'h1F, 8'h00, 8'h7F, 1, 24'h000000, 8'h03};
        vecs[11] = '{8'h0A, 8'h10, 8'h55, 8'h7F, 0, 24'h000000, 8'h03};
        vecs[12] = '{8'h0A, 8'h2D, 8'h02, 8'h7F, 0, 24'h000000, 8'h02};
        vecs[13] = '{8'h0B, 8'h0A, 8'h00, 8'h5A, 1, 24'h000044, 8'h02};
        vecs[14] = '{8'h0B, 8'h02, 8'h00, 8'h5A, 1, 24'h0000F2, 8'h02};

        rst = 1'b1;
        ACL_SCLK = 1'b0;
        ACL_CSN = 1'b1;
        ACL_MOSI = 1'b0;
        accel_x_i = 8'h00;
        accel_y_i = 8'h33;
        accel_z_i = 8'h44;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        check("reset_miso", 32'(ACL_MISO), 32'h0);
        check("reset_pctl", 32'(power_ctl_o), 32'h00);
        check("reset_done", 32'(xfer_done_o), 32'h0);
        check("reset_err", 32'(cmd_err_o), 32'h0);

        for (int v = 0; v < 15; v++) begin
            d0 = n_done;
            e0 = n_err;
            accel_x_i = vecs[v].x;
            rd = 24'h0;
            csn_lo();
            xfer(vecs[v].cmd, 8, rx);
            xfer(vecs[v].addr, 8, rx);
            if (vecs[v].nrd == 0) begin
                xfer(vecs[v].wdata, 8, rx);
            end else begin
                for (int b = 0; b < int'(vecs[v].nrd); b++) begin
                    xfer(8'h00, 8, rx);
                    rd = {rd[15:0], rx};
                end
            end
            csn_hi();
            if (vecs[v].nrd != 0)
                check($sformatf("vec%0d_rdata", v), 32'(rd), 32'(vecs[v].exp_rd));
            check($sformatf("vec%0d_pctl", v), 32'(power_ctl_o), 32'(vecs[v].exp_pctl));
            check($sformatf("vec%0d_done", v), 32'(n_done - d0), 32'd1);
            check($sformatf("vec%0d_err", v), 32'(n_err - e0), 32'd0);
        end

        // Snapshot held although accel_x_i changes mid-frame; next frame re-latches
        accel_x_i = 8'h7F;
        csn_lo();
        xfer(8'h0B, 8, rx);
        accel_x_i = 8'h10;
        xfer(8'h08, 8, rx);
        xfer(8'h00, 8, rx);
        csn_hi();
        check("snap_hold", 32'(rx), 32'h7F);
        read1(8'h08, rx);
        check("snap_new", 32'(rx), 32'h10);

        // Unrecognised command
        e0 = n_err;
        m0 = n_miso;
        csn_lo();
        xfer(8'h55, 8, rx);
        xfer(8'h2D, 8, rx);
        xfer(8'h00, 8, rx);
        csn_hi();
        check("badcmd_err", 32'(n_err - e0), 32'd1);
        check("badcmd_miso", 32'(n_miso - m0), 32'd0);
        check("badcmd_pctl", 32'(power_ctl_o), 32'h02);

        // Abort after 5 bits of a write data byte
        d0 = n_done;
        csn_lo();
        xfer(8'h0A, 8, rx);
        xfer(8'h2D, 8, rx);
        xfer(8'hFF, 5, rx);
        csn_hi();
        check("abort_pctl", 32'(power_ctl_o), 32'h02);
        check("abort_done", 32'(n_done - d0), 32'd1);

        // Reset in the middle of a DEVID read
        csn_lo();
        xfer(8'h0B, 8, rx);
        xfer(8'h00, 8, rx);
        xfer(8'h00, 3, rx);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_miso", 32'(ACL_MISO), 32'h0);
        check("midrst_pctl", 32'(power_ctl_o), 32'h00);
        check("midrst_done", 32'(xfer_done_o), 32'h0);
        check("midrst_err", 32'(cmd_err_o), 32'h0);
        @(negedge clk);
        m0 = n_miso;
        e0 = n_err;
        xfer(8'h00, 5, rx);
        xfer(8'h0B, 8, rx);
        xfer(8'h00, 8, rx);
        check("midrst_rest_miso", 32'(n_miso - m0), 32'd0);
        check("midrst_rest_err", 32'(n_err - e0), 32'd0);
        csn_hi();
        d0 = n_done;
        read1(8'h00, rx);
        check("postrst_devid", 32'(rx), 32'hAD);
        check("postrst_done", 32'(n_done - d0), 32'd1);
        check("postrst_pctl", 32'(power_ctl_o), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
